fifo_sram_writer: RTL and testbench
===================================

# fifo_sram_writer

Wishbone master write stage directly downstream of `fifo_to_sram`. It accepts one 32-bit word per `sram_start` pulse, writes it to SRAM at a sequential word address, and returns a one-cycle `data_done` pulse so `fifo_to_sram` can pop the next sample. The address pointer walks a circular window of `DEPTH` words starting at `BASE_ADDR`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0 of the window; must be 4-byte aligned.
- `DEPTH`, 256: window size in words; legal range 1..65536.
- `TIMEOUT`, 15: ack wait limit in cycles; used only with `FIFO_SRAM_WRITER_TIMEOUT_EN`.

Ports:
- `wb_clk` in 1: the single clock.
- `wb_rst` in 1: reset, synchronous, active-high.
- `sram_start` in 1: one-cycle request pulse from `fifo_to_sram`.
- `sram_data_in` in 32: write data; valid in the `sram_start` cycle.
- `data_done` out 1: one-cycle completion pulse back to `fifo_to_sram`.
- `clear` in 1: resets the pointer, `write_count`, `wrapped` and `error`.
- `wb_m_adr_o` out 32: byte address.
- `wb_m_dat_o` out 32: write data.
- `wb_m_sel_o` out 4: byte selects; always 4'hF while `stb` is high.
- `wb_m_we_o` out 1: write enable.
- `wb_m_cyc_o` out 1: bus cycle.
- `wb_m_stb_o` out 1: strobe.
- `wb_m_ack_i` in 1: slave acknowledge.
- `wb_m_err_i` in 1: slave error.
- `busy` out 1: high while in WRITE.
- `write_count` out 16: successful writes; saturates at 16'hFFFF.
- `wrapped` out 1: sticky; set when the pointer rolls from DEPTH-1 to 0.
- `error` out 1: sticky; set on an err or timeout termination.

## Operation
- States: IDLE, WRITE.
- IDLE, `sram_start`=1:
  - latch `sram_data_in` to `wb_m_dat_o`;
  - drive `wb_m_adr_o` = BASE_ADDR + 4·ptr;
  - assert `cyc`, `stb`, `we`, `sel`=F;
  - go to WRITE.
- WRITE, `ack`=1:
  - drop `cyc`, `stb`, `we` and `sel`;
  - pulse `data_done`;
  - ptr = (ptr==DEPTH-1) ? 0 : ptr+1; set `wrapped` on rollover;
  - `write_count`++;
  - go to IDLE.
- WRITE, `err`=1 (and `ack`=0):
  - terminate the cycle the same way and pulse `data_done`;
  - set `error`;
  - ptr and `write_count` unchanged.
  - `ack` and `err` high together are treated as `ack`.
- `sram_start` while in WRITE is ignored; `fifo_to_sram` never issues it.
- `clear`:
  - zeroes ptr, `write_count`, `wrapped` and `error` at the edge it is sampled, with priority over increment and flag set;
  - never aborts an in-flight bus cycle, and that cycle still pulses `data_done`.
- `wb_m_dat_o` and `wb_m_adr_o` hold their last values after a cycle ends.

## Timing
- Reset values: `cyc`, `stb`, `we`, `data_done`, `busy`, `wrapped` and `error` = 0; `sel` = 0; `adr`, `dat`, `write_count` and ptr = 0. State = IDLE.
- `wb_rst` aborts any bus cycle at that edge, and no `data_done` is issued.
- All outputs are registered.
- With `sram_start` sampled at edge N:
  - `cyc`, `stb` and `busy` are high from edge N.
  - With a zero-wait slave, `ack` is sampled at edge N+1. `cyc` and `stb` drop and `data_done` is high for exactly the cycle after edge N+1.
- Minimum request-to-done time is 2 cycles; each slave wait state adds 1.
- `data_done` is never wider than one cycle. Back-to-back requests are accepted the cycle after `data_done`.

## Configuration
- `FIFO_SRAM_WRITER_TIMEOUT_EN` defined:
  - a 4-bit-or-wider wait counter runs in WRITE;
  - if `ack` and `err` stay low for TIMEOUT consecutive sampled edges, terminate exactly as for `err` (pulse `data_done`, set `error`, ptr held).
- Undefined:
  - no counter is built;
  - WRITE waits indefinitely for `ack` or `err`.

## Test plan
- Reset: hold `wb_rst` 8 cycles -> all outputs 0 after release; `cyc`=0.
- Zero-wait slave, 5 requests with data A5B6C7D8, E9FA0123, 4567890A, 55555555, AAAAAAAA:
  - addresses 0x0, 0x4, 0x8, 0xC, 0x10 with the matching data;
  - `data_done` 2 cycles after each `sram_start`, one cycle wide;
  - `write_count`=5.
- DEPTH=4, BASE_ADDR=0x100, 5 writes:
  - 5th address = 0x100;
  - `wrapped`=1 after the 4th ack.
- Slave with 3 wait states:
  - `stb` high for 4 cycles;
  - `data_done` 5 cycles after `sram_start`;
  - `dat` stable throughout.
- `err` on 2nd write:
  - `error`=1 and `data_done` pulses;
  - 3rd write reuses the 2nd write's address;
  - `write_count`=2 after 3 requests.
- Timeout (macro on, TIMEOUT=15), slave never acks:
  - `data_done` at 15 waits;
  - `error`=1.
  - Macro off: `cyc` still high after 100 cycles.

Source files
------------

// File: rtl/fifo_sram_writer_if.sv
// Wishbone classic write-master bus between fifo_sram_writer and the SRAM slave.
interface fifo_sram_writer_if;
   logic [31:0] wb_m_adr_o;
   logic [31:0] wb_m_dat_o;
   logic [3:0]  wb_m_sel_o;
   logic        wb_m_we_o;
   logic        wb_m_cyc_o;
   logic        wb_m_stb_o;
   logic        wb_m_ack_i;
   logic        wb_m_err_i;

   modport master (
      output wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
      input  wb_m_ack_i, wb_m_err_i
   );

   modport slave (
      input  wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
      output wb_m_ack_i, wb_m_err_i
   );
endinterface

// File: rtl/fifo_sram_writer.sv
// Single-word Wishbone write stage walking a circular DEPTH-word SRAM window.
// Optional ack timeout is built only when FIFO_SRAM_WRITER_TIMEOUT_EN is defined.
module fifo_sram_writer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                wb_clk,
   input  logic                wb_rst,
   input  logic                sram_start,
   input  logic [31:0]         sram_data_in,
   output logic                data_done,
   input  logic                clear,
   fifo_sram_writer_if.master  wb,
   output logic                busy,
   output logic [15:0]         write_count,
   output logic                wrapped,
   output logic                error
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_IDLE, S_WRITE} state_e;

   state_e        state_q;
   logic [31:0]   adr_q;
   logic [31:0]   dat_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic          cyc_q;
   logic          stb_q;
   logic          done_q;
   logic          busy_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [15:0]   cnt_q;
   logic          wrap_q;
   logic          err_q;
   logic          ptr_last;
   logic          timeout_hit;

`ifdef FIFO_SRAM_WRITER_TIMEOUT_EN
   localparam int unsigned WW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
   logic [WW-1:0] wait_q;

   // Fires on the TIMEOUT-th consecutive edge sampled with neither ack nor err.
   always_comb begin
      timeout_hit = 1'b0;
      if (state_q == S_WRITE && !wb.wb_m_ack_i && !wb.wb_m_err_i
          && wait_q == WW'(TIMEOUT - 1))
         timeout_hit = 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign ptr_last = (ptr_q == PW'(DEPTH - 1));
   assign ptr_d    = ptr_last ? '0 : ptr_q + 1'b1;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef FIFO_SRAM_WRITER_TIMEOUT_EN
         wait_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sram_start) begin
                  dat_q   <= sram_data_in;
                  adr_q   <= BASE_ADDR + (32'(ptr_q) << 2);
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b1;
                  sel_q   <= 4'hF;
                  busy_q  <= 1'b1;
                  state_q <= S_WRITE;
`ifdef FIFO_SRAM_WRITER_TIMEOUT_EN
                  wait_q  <= '0;
`endif
               end
            end
            S_WRITE: begin
               if (wb.wb_m_ack_i || wb.wb_m_err_i || timeout_hit) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
`ifdef FIFO_SRAM_WRITER_TIMEOUT_EN
               else begin
                  wait_q <= wait_q + 1'b1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase

         // Bookkeeping: clear wins over any update on the same edge but leaves the bus cycle alone.
         if (clear) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
         end else if (state_q == S_WRITE) begin
            if (wb.wb_m_ack_i) begin
               ptr_q <= ptr_d;
               if (ptr_last)
                  wrap_q <= 1'b1;
               if (cnt_q != 16'hFFFF)
                  cnt_q <= cnt_q + 16'd1;
            end else if (wb.wb_m_err_i || timeout_hit) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign wb.wb_m_adr_o = adr_q;
   assign wb.wb_m_dat_o = dat_q;
   assign wb.wb_m_sel_o = sel_q;
   assign wb.wb_m_we_o  = we_q;
   assign wb.wb_m_cyc_o = cyc_q;
   assign wb.wb_m_stb_o = stb_q;
   assign data_done     = done_q;
   assign busy          = busy_q;
   assign write_count   = cnt_q;
   assign wrapped       = wrap_q;
   assign error         = err_q;

endmodule

// File: tb/tb_fifo_sram_writer.sv
// Self-checking bench: default-window DUT and a 4-word window at 0x100, checked against a behavioural model.
module tb_fifo_sram_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_r [2];
   logic [31:0] din_r   [2];
   logic        clear_r [2];
   logic        ack_r   [2];
   logic        err_r   [2];

   logic [31:0] adr_m [2];
   logic [31:0] dat_m [2];
   logic [3:0]  sel_m [2];
   logic        we_m  [2];
   logic        cyc_m [2];
   logic        stb_m [2];
   logic        done_m[2];
   logic        busy_m[2];
   logic [15:0] cnt_m [2];
   logic        wrap_m[2];
   logic        err_m [2];

   fifo_sram_writer_if bus0 ();
   fifo_sram_writer_if bus1 ();

   assign bus0.wb_m_ack_i = ack_r[0];
   assign bus0.wb_m_err_i = err_r[0];
   assign bus1.wb_m_ack_i = ack_r[1];
   assign bus1.wb_m_err_i = err_r[1];

   assign adr_m[0] = bus0.wb_m_adr_o;  assign adr_m[1] = bus1.wb_m_adr_o;
   assign dat_m[0] = bus0.wb_m_dat_o;  assign dat_m[1] = bus1.wb_m_dat_o;
   assign sel_m[0] = bus0.wb_m_sel_o;  assign sel_m[1] = bus1.wb_m_sel_o;
   assign we_m[0]  = bus0.wb_m_we_o;   assign we_m[1]  = bus1.wb_m_we_o;
   assign cyc_m[0] = bus0.wb_m_cyc_o;  assign cyc_m[1] = bus1.wb_m_cyc_o;
   assign stb_m[0] = bus0.wb_m_stb_o;  assign stb_m[1] = bus1.wb_m_stb_o;

   fifo_sram_writer dut0 (
      .wb_clk       (clk),
      .wb_rst       (rst),
      .sram_start   (start_r[0]),
      .sram_data_in (din_r[0]),
      .data_done    (done_m[0]),
      .clear        (clear_r[0]),
      .wb           (bus0),
      .busy         (busy_m[0]),
      .write_count  (cnt_m[0]),
      .wrapped      (wrap_m[0]),
      .error        (err_m[0])
   );

   fifo_sram_writer #(.BASE_ADDR(32'h0000_0100), .DEPTH(4), .TIMEOUT(15)) dut1 (
      .wb_clk       (clk),
      .wb_rst       (rst),
      .sram_start   (start_r[1]),
      .sram_data_in (din_r[1]),
      .data_done    (done_m[1]),
      .clear        (clear_r[1]),
      .wb           (bus1),
      .busy         (busy_m[1]),
      .write_count  (cnt_m[1]),
      .wrapped      (wrap_m[1]),
      .error        (err_m[1])
   );

   // Reference model: window geometry plus architectural pointer/counter/flags per instance.
   int unsigned mbase [2] = '{32'h0, 32'h100};
   int unsigned mdepth[2] = '{256, 4};
   int unsigned mptr  [2];
   int unsigned mcnt  [2];
   bit          mwrap [2];
   bit          merr  [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int d);
      mptr[d] = 0; mcnt[d] = 0; mwrap[d] = 1'b0; merr[d] = 1'b0;
   endtask

   task automatic chk_flags(input int d, input string tag);
      chk({tag, "_cnt"},  32'(cnt_m[d]),  32'(mcnt[d]));
      chk({tag, "_wrap"}, 32'(wrap_m[d]), 32'(mwrap[d]));
      chk({tag, "_err"},  32'(err_m[d]),  32'(merr[d]));
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk({tag, "_cyc"},  32'(cyc_m[d]),  32'd0);
      chk({tag, "_stb"},  32'(stb_m[d]),  32'd0);
      chk({tag, "_we"},   32'(we_m[d]),   32'd0);
      chk({tag, "_sel"},  32'(sel_m[d]),  32'd0);
      chk({tag, "_busy"}, 32'(busy_m[d]), 32'd0);
   endtask

   // mode: 0 = ack, 1 = err, 2 = ack+err together. clr_w >= 0 pulses clear on that wait edge.
   task automatic do_write(input int d, input logic [31:0] data, input int waits,
                           input int mode, input int clr_w);
      logic [31:0] exp_adr;
      bit last;
      exp_adr = mbase[d] + 4 * mptr[d];
      @(negedge clk);
      start_r[d] = 1'b1;
      din_r[d]   = data;
      @(posedge clk); #1;
      start_r[d] = 1'b0;
      din_r[d]   = $urandom;
      chk("start_cyc",  32'(cyc_m[d]),  32'd1);
      chk("start_stb",  32'(stb_m[d]),  32'd1);
      chk("start_we",   32'(we_m[d]),   32'd1);
      chk("start_sel",  32'(sel_m[d]),  32'hF);
      chk("start_busy", 32'(busy_m[d]), 32'd1);
      chk("start_adr",  adr_m[d], exp_adr);
      chk("start_dat",  dat_m[d], data);
      chk("start_done", 32'(done_m[d]), 32'd0);
      for (int w = 0; w < waits; w++) begin
         @(negedge clk);
         if (w == clr_w) clear_r[d] = 1'b1;
         @(posedge clk); #1;
         clear_r[d] = 1'b0;
         if (w == clr_w) model_clear(d);
         chk("wait_stb",  32'(stb_m[d]),  32'd1);
         chk("wait_dat",  dat_m[d], data);
         chk("wait_done", 32'(done_m[d]), 32'd0);
      end
      @(negedge clk);
      ack_r[d] = (mode != 1);
      err_r[d] = (mode != 0);
      @(posedge clk); #1;
      ack_r[d] = 1'b0;
      err_r[d] = 1'b0;
      if (mode != 1) begin
         last = (mptr[d] == mdepth[d] - 1);
         mptr[d] = last ? 0 : mptr[d] + 1;
         if (last) mwrap[d] = 1'b1;
         if (mcnt[d] < 65535) mcnt[d]++;
      end else begin
         merr[d] = 1'b1;
      end
      chk("end_done", 32'(done_m[d]), 32'd1);
      chk_idle(d, "end");
      chk("end_adr_hold", adr_m[d], exp_adr);
      chk("end_dat_hold", dat_m[d], data);
      chk_flags(d, "end");
      @(posedge clk); #1;
      chk("done_width", 32'(done_m[d]), 32'd0);
   endtask

   task automatic do_clear(input int d);
      @(negedge clk);
      clear_r[d] = 1'b1;
      @(posedge clk); #1;
      clear_r[d] = 1'b0;
      model_clear(d);
      chk_flags(d, "clear");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [31:0] vec5 [5];
      logic [31:0] adr2;
      int cycles;
      vec5 = '{32'hA5B6C7D8, 32'hE9FA0123, 32'h4567890A, 32'h55555555, 32'hAAAAAAAA};
      for (int d = 0; d < 2; d++) begin
         start_r[d] = 1'b0; din_r[d] = '0; clear_r[d] = 1'b0;
         ack_r[d] = 1'b0; err_r[d] = 1'b0;
         model_clear(d);
      end

      // Reset held for 8 cycles, then every output must read zero.
      rst = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk_idle(d, "rst");
         chk("rst_adr",  adr_m[d], 32'd0);
         chk("rst_dat",  dat_m[d], 32'd0);
         chk("rst_done", 32'(done_m[d]), 32'd0);
         chk_flags(d, "rst");
      end

      // Zero-wait writes of the reference data set.
      for (int i = 0; i < 5; i++) do_write(0, vec5[i], 0, 0, -1);
      chk("count5", 32'(cnt_m[0]), 32'd5);

      // Small window: wraps back to 0x100 on the fifth write.
      for (int i = 0; i < 5; i++) begin
         do_write(1, $urandom, 0, 0, -1);
         if (i == 2) chk("wrap_after3", 32'(wrap_m[1]), 32'd0);
         if (i == 3) chk("wrap_after4", 32'(wrap_m[1]), 32'd1);
      end
      chk("wrap_adr5", adr_m[1], 32'h0000_0100);

      // Three wait states.
      do_write(0, 32'hC0FFEE01, 3, 0, -1);

      // Error on the second of three writes.
      do_clear(0);
      do_write(0, 32'h11111111, 0, 0, -1);
      do_write(0, 32'h22222222, 1, 1, -1);
      adr2 = adr_m[0];
      chk("err_flag", 32'(err_m[0]), 32'd1);
      do_write(0, 32'h33333333, 0, 0, -1);
      chk("err_adr_reuse", adr_m[0], adr2);
      chk("err_count", 32'(cnt_m[0]), 32'd2);

      // ack and err together count as ack; clear during an in-flight cycle.
      do_write(0, 32'h44444444, 0, 2, -1);
      do_write(0, 32'h66666666, 2, 0, 0);
      chk("clr_inflight_cnt", 32'(cnt_m[0]), 32'd1);

      // Randomized traffic over both instances.
      for (int i = 0; i < 40; i++) begin
         int d, waits, mode, clr_w;
         d     = int'($urandom_range(1, 0));
         waits = int'($urandom_range(4, 0));
         mode  = ($urandom_range(7, 0) == 0) ? 1 : (($urandom_range(7, 0) == 0) ? 2 : 0);
         clr_w = (waits > 0 && $urandom_range(9, 0) == 0) ? int'($urandom_range(waits - 1, 0)) : -1;
         do_write(d, $urandom, waits, mode, clr_w);
      end

      // Slave that never answers.
      @(negedge clk);
      start_r[0] = 1'b1;
      din_r[0]   = 32'hDEADBEEF;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      chk("hang_cyc", 32'(cyc_m[0]), 32'd1);
`ifdef FIFO_SRAM_WRITER_TIMEOUT_EN
      cycles = 0;
      while (!done_m[0] && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
      merr[0] = 1'b1;
      chk("timeout_latency", 32'(cycles), 32'd15);
      chk("timeout_done", 32'(done_m[0]), 32'd1);
      chk_idle(0, "timeout");
      chk_flags(0, "timeout");
`else
      cycles = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (done_m[0]) cycles++;
      end
      chk("nohang_cyc", 32'(cyc_m[0]), 32'd1);
      chk("nohang_done_seen", 32'(cycles), 32'd0);
`endif

      // Reset aborts whatever is in flight without a done pulse.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_clear(d);
         chk_idle(d, "abort");
         chk("abort_done", 32'(done_m[d]), 32'd0);
         chk_flags(d, "abort");
      end
      @(posedge clk); #1;
      chk("abort_done_next", 32'(done_m[0]), 32'd0);
      do_write(0, 32'h0BADF00D, 0, 0, -1);
      chk("post_abort_adr", adr_m[0], 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
